round: RTL and testbench
========================

Name: round

Overview:
- One AES-128 encryption round on a 128-bit state: SubBytes, ShiftRows, MixColumns, AddRoundKey, in FIPS-197 order.
- Result is registered, so a round is computed every clock.
- Sits inside the cipher datapath. The top-level sequencer feeds it the current state and round key and chains ten instances, or iterates one instance ten times.
- A parameter selects final-round operation, in which MixColumns is omitted.

Parameters:
- FINAL_ROUND, default 0. 0 = full round. 1 = final round, MixColumns bypassed.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  reset; asynchronous, active-low (0 = reset asserted).
- roundin  input  128  state entering the round.
- key  input  128  round key for this round.
- roundout  output  128  registered state leaving the round.

Behaviour:
- Byte mapping, FIPS-197 column-major:
  - Byte k = bits[127-8k : 120-8k], for k = 0..15.
  - Byte k is state element s[r][c], with r = k mod 4 and c = k div 4.
  - key uses the same mapping.
- SubBytes:
  - Replace each byte with the AES forward S-box value.
  - Implement as a combinational 256-entry lookup, replicated 16 times or shared as a function.
  - Examples: S(00) = 63, S(53) = ED, S(FF) = 16.
- ShiftRows: s'[r][c] = s[r][(c+r) mod 4]. Row 0 is unchanged; rows 1, 2, 3 rotate left by 1, 2, 3 bytes.
- MixColumns, per column, arithmetic in GF(2^8) with polynomial 0x11B:
  - b0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - b1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - b2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - b3 = 3a0 ^ a1 ^ a2 ^ 2a3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); 3x = xtime(x) ^ x.
  - Bypassed (identity) when FINAL_ROUND = 1.
- AddRoundKey: bitwise XOR of the 128-bit result with key.
- Pipeline and timing:
  - The four steps are purely combinational from roundin/key to the D input of a single 128-bit register.
  - Latency is one clock: roundout at edge n+1 reflects the roundin/key sampled at edge n.
  - Throughput is one round per clock; there is no handshake and no enable.
  - Inputs must be stable for setup before each rising clk.
- Reset:
  - While rst = 0, roundout is forced to 128'h0 immediately, without waiting for a clock edge.
  - Reset asserted mid-operation discards the pending result.
  - The first rising clk after rst returns to 1 loads the round result of the current inputs.
- Inputs with X/Z are outside contract; there is no internal state beyond the output register.

Test Plan:
- Reset: drive rst = 0 with arbitrary inputs, no clock edge -> roundout = 0 at once. Release rst; after 1 clk -> valid result.
- All-zero, FINAL_ROUND = 0: roundin = 0, key = 0, 1 clk -> roundout = 6363…63 (16 bytes of 63).
- FIPS-197 round 1, FINAL_ROUND = 0:
  - roundin = 193de3bea0f4e22b9ac68d2ae9f84808
  - key = a0fafe1788542cb123a339392a6c7605
  - -> roundout = a49c7ff2689f352b6b5bea43026a5049
- FIPS-197 final round, FINAL_ROUND = 1:
  - roundin = eb40f21e592e38848ba113e71bc342d2
  - key = d014f9a8c9ee2589e13f0cc8b6630ca6
  - -> roundout = 3925841d02dc09fbdc118597196a0b32
- Back-to-back: apply the round 1 vector, then the all-zero vector on consecutive clocks -> outputs appear on consecutive cycles with 1-cycle latency, no bubbles.
- Key isolation: repeat the round 1 vector with key = ffff…ff -> roundout = bitwise NOT of the key = 0 result for the same roundin.

Source files
------------

// File: rtl/round.sv
// One AES-128 encryption round: SubBytes, ShiftRows, MixColumns (unless
// FINAL_ROUND), AddRoundKey. Everything is combinational from roundin/key
// into a single 128-bit output register, so one round completes per clock.
// Interface: no handshake and no enable; roundout at edge n+1 reflects the
// roundin/key sampled at edge n. rst is asynchronous, active-low, and clears
// roundout to zero immediately.
`timescale 1ns/1ps
module round #(
  parameter int unsigned FINAL_ROUND = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] roundin,
  input  logic [127:0] key,
  output logic [127:0] roundout
);

  // AES forward S-box, indexed by the input byte value.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // Byte k lives at bits [127-8k -: 8] and is state element s[k%4][k/4].
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];
  logic [127:0] next_state;

  // SubBytes: independent S-box lookup on every byte.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      sb[k] = sub_byte(roundin[127-8*k -: 8]);
    end
  end

  // ShiftRows: row r rotates left by r, i.e. s'[r][c] = s[r][(c+r)%4].
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
      end
    end
  end

  // MixColumns on each column; the final round passes ShiftRows through.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      if (FINAL_ROUND != 0) begin
        mc[4*c]     = sr[4*c];
        mc[4*c + 1] = sr[4*c + 1];
        mc[4*c + 2] = sr[4*c + 2];
        mc[4*c + 3] = sr[4*c + 3];
      end else begin
        mc[4*c]     = xtime(sr[4*c]) ^ mul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
        mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ mul3(sr[4*c+2]) ^ sr[4*c+3];
        mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ mul3(sr[4*c+3]);
        mc[4*c + 3] = mul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
    end
  end

  // AddRoundKey: repack the bytes and XOR with the round key.
  always_comb begin
    next_state = '0;
    for (int k = 0; k < 16; k++) begin
      next_state[127-8*k -: 8] = mc[k] ^ key[127-8*k -: 8];
    end
  end

  // Output register; reset clears it at once and drops any pending result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      roundout <= '0;
    end else begin
      roundout <= next_state;
    end
  end

endmodule

// File: tb/tb_round.sv
// Bench for round: a full-round and a final-round instance share the same
// inputs. The driver pushes expected results into exp_q as it applies each
// vector; a monitor pops and compares one cycle later, when vld_out shows a
// tracked vector has been registered.
`timescale 1ns/1ps
module tb_round;

  localparam int W = 258;  // {chk_full, exp_full, chk_final, exp_final}

  localparam logic [127:0] ZERO     = 128'h0;
  localparam logic [127:0] ONES     = {128{1'b1}};
  localparam logic [127:0] R1_IN    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1_KEY   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R1_OUT   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] R1_NOTK  = 128'hfb997e1a1f34e665b7072c85d7f9d9b3;
  localparam logic [127:0] R10_IN   = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [127:0] R10_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R10_OUT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R10_K0   = 128'he9317db5cb322c723d2e895faf090794;
  localparam logic [127:0] ALL_63   = {16{8'h63}};
  localparam logic [127:0] ALL_9C   = {16{8'h9c}};
  localparam logic [127:0] ALL_53   = {16{8'h53}};
  localparam logic [127:0] ALL_ED   = {16{8'hed}};
  localparam logic [127:0] ALL_FF   = {16{8'hff}};
  localparam logic [127:0] ALL_16   = {16{8'h16}};

  // Clock and reset
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] roundin = '0;
  logic [127:0] key = '0;
  logic [127:0] out_full;
  logic [127:0] out_final;

  always #5 clk = ~clk;

  round #(.FINAL_ROUND(0)) u_full (
    .clk(clk), .rst(rst), .roundin(roundin), .key(key), .roundout(out_full)
  );

  round #(.FINAL_ROUND(1)) u_final (
    .clk(clk), .rst(rst), .roundin(roundin), .key(key), .roundout(out_final)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_e;
  logic         vld_in  = 1'b0;
  logic         vld_out = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Driver: apply one vector on a falling edge and record what to expect.
  task automatic apply(input logic [127:0] rin, input logic [127:0] k,
                       input logic cf, input logic [127:0] ef,
                       input logic cl, input logic [127:0] el);
    @(negedge clk);
    roundin = rin;
    key     = k;
    vld_in  = 1'b1;
    exp_q.push_back({cf, ef, cl, el});
  endtask

  task automatic idle();
    @(negedge clk);
    vld_in = 1'b0;
  endtask

  // Tracks which registered outputs belong to scoreboarded vectors.
  always @(posedge clk or negedge rst) begin
    if (!rst) vld_out <= 1'b0;
    else      vld_out <= vld_in;
  end

  // Monitor: compare just after each edge that registered a tracked vector.
  always @(posedge clk) begin
    #1;
    if (vld_out) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected no output", out_full);
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e[257]) check("full_round", out_full, exp_e[256:129]);
        if (exp_e[128]) check("final_round", out_final, exp_e[127:0]);
      end
    end
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #1;
    roundin = $urandom_range(0, 32'hffff_ffff);
    key     = $urandom_range(0, 32'hffff_ffff);
    rst     = 1'b0;
    #1;
    check("reset_async_full", out_full, ZERO);
    check("reset_async_final", out_final, ZERO);
    #5;
    rst = 1'b1;

    // Back-to-back burst; the first edge after release loads vector one.
    apply(ZERO,   ZERO,    1'b1, ALL_63,  1'b1, ALL_63);
    apply(R1_IN,  R1_KEY,  1'b1, R1_OUT,  1'b0, ZERO);
    apply(ZERO,   ZERO,    1'b1, ALL_63,  1'b1, ALL_63);
    apply(R10_IN, R10_KEY, 1'b0, ZERO,    1'b1, R10_OUT);
    apply(R1_IN,  ONES,    1'b1, R1_NOTK, 1'b0, ZERO);
    apply(R1_IN,  ONES,    1'b1, ~(R1_OUT ^ R1_KEY), 1'b0, ZERO);
    apply(R10_IN, ZERO,    1'b0, ZERO,    1'b1, R10_K0);
    apply(ALL_53, ZERO,    1'b1, ALL_ED,  1'b1, ALL_ED);
    apply(ALL_FF, ZERO,    1'b1, ALL_16,  1'b1, ALL_16);
    apply(ZERO,   ONES,    1'b1, ALL_9C,  1'b1, ALL_9C);
    idle();
    repeat (2) @(posedge clk);

    // Reset mid-operation: load a result, then drop it without a clock edge.
    apply(R1_IN, R1_KEY, 1'b1, R1_OUT, 1'b0, ZERO);
    idle();
    #2;
    rst = 1'b0;
    #1;
    check("reset_mid_full", out_full, ZERO);
    check("reset_mid_final", out_final, ZERO);
    @(posedge clk);
    #1;
    check("reset_hold_full", out_full, ZERO);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release_full", out_full, R1_OUT);

    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
